lenet_run_ctrl: RTL and testbench
=================================

Name: lenet_run_ctrl

Overview:
- Host-side initiator for the LeNet accelerator `top`, driving the far end of its start/busy/done/result handshake.
- Accepts a batch command of N images and issues one single-cycle `acc_start` pulse per image.
- Waits for `acc_done` on each image, with a watchdog timeout.
- Buffers each captured result, its measured latency and a timeout flag in a small FIFO, read out over valid/ready.

Parameters:
- DATA_WIDTH, 8, width of `acc_result` and `res_data`.
- CNT_W, 4, width of the batch image count.
- CYC_W, 16, width of the latency counter.
- TIMEOUT_CYCLES, 3000, WAIT cycles allowed before an image is declared timed out; must be ≥2 and ≤ 2^CYC_W-1.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥2.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset. Synchronous, active-low.
- cmd_valid, in, 1, batch command offered.
- cmd_ready, out, 1, high only in IDLE.
- cmd_count, in, CNT_W, number of images in the batch.
- acc_start, out, 1, single-cycle start pulse to the accelerator.
- acc_busy, in, 1, accelerator busy. Status only; not used for control.
- acc_done, in, 1, accelerator done; sampled only in WAIT.
- acc_result, in, DATA_WIDTH, classification result; valid in the `acc_done` cycle.
- res_valid, out, 1, FIFO non-empty.
- res_ready, in, 1, consumer pops the head entry.
- res_data, out, DATA_WIDTH, head entry result.
- res_cycles, out, CYC_W, head entry latency.
- res_timeout, out, 1, head entry timed out.
- img_index, out, CNT_W, index of the current image in the batch.
- idle, out, 1, FSM is in IDLE.
- err_timeout, out, 1, sticky timeout flag; cleared only by reset.

Behaviour:

Reset (`rst_n`=0 sampled at posedge):
- FSM goes to IDLE; FIFO is emptied.
- All outputs go to 0, except `cmd_ready`=1 and `idle`=1.
- Reset mid-batch aborts immediately. `acc_start` is 0 from the next edge, and no partial entry is pushed.

FSM states: IDLE, ARM, PULSE, WAIT, PUSH.
- IDLE:
  - On `cmd_valid`&&`cmd_ready`, latch `cmd_count` into `remaining` and clear `img_index`.
  - If `cmd_count`==0: stay in IDLE; no start is issued and nothing is pushed.
  - Otherwise go to ARM.
- ARM:
  - Wait until FIFO occupancy < FIFO_DEPTH, then go to PULSE.
  - This guarantees the in-flight image always has a slot, so the FIFO never overflows.
- PULSE:
  - `acc_start`=1 for exactly this one cycle.
  - Clear the latency counter `lat` to 0, then go to WAIT.
- WAIT:
  - `acc_done`=1: capture `acc_result`, set cycles=`lat`+1 and timeout=0, go to PUSH.
  - Else if `lat`==TIMEOUT_CYCLES-1: set data=0, cycles=TIMEOUT_CYCLES, timeout=1, `err_timeout`<=1, force `remaining` to 1 (abort the rest of the batch), go to PUSH.
  - Else: `lat`<=`lat`+1.
  - `acc_done` and the timeout in the same cycle: done wins.
- PUSH:
  - Write the captured entry into the FIFO; this is one write, in this cycle.
  - Decrement `remaining`.
  - If `remaining` was 1, go to IDLE. Otherwise increment `img_index` (wraps modulo 2^CNT_W) and go to ARM.

Latency:
- `acc_done` seen in the first WAIT cycle (the cycle after the pulse) reports res_cycles=1.

FIFO:
- Synchronous; first-word fall-through outputs.
- `res_data`/`res_cycles`/`res_timeout` hold stable while `res_valid`&&!`res_ready`.
- Push and pop in the same cycle: both take effect and occupancy is unchanged.
- Pop when empty: ignored.
- Read/write pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a separate counter of width log2(FIFO_DEPTH)+1.

Other rules:
- `acc_done` outside WAIT is ignored, including spurious or late `done` after a timeout.
- `cmd_valid` outside IDLE is ignored because `cmd_ready`=0.

Test Plan:
1. Reset, then cmd_count=1; model asserts `acc_done` 5 cycles after the pulse with result 8'd7 → exactly one `acc_start` pulse; FIFO entry {data=7, cycles=5, timeout=0}; `idle`=1 the cycle after PUSH.
2. cmd_count=3, results 3/1/9 at latencies 2/4/2, `res_ready`=1 → three pulses, each separated by at least 3 cycles; entries popped in order 3,1,9; `img_index` goes 0,1,2.
3. cmd_count=6, FIFO_DEPTH=4, `res_ready`=0, done latency 1 → four pulses, then FSM holds in ARM with `acc_start` low. Raising `res_ready` for 1 cycle → a fifth pulse follows; all 6 entries are eventually delivered in order.
4. cmd_count=2, first image never asserts done → at WAIT cycle 3000 entry {0, 3000, 1} is pushed; `err_timeout`=1; no second pulse; a later `acc_done` is ignored; `idle`=1.
5. cmd_count=0 → handshake completes in 1 cycle; no `acc_start`; `res_valid` stays 0.
6. Assert `rst_n`=0 during WAIT of image 1 of 3 → next edge: `acc_start`=0, `res_valid`=0, `idle`=1, `err_timeout`=0. A fresh cmd_count=1 afterwards runs normally.

Source files
------------

// File: rtl/lenet_run_ctrl.sv
// Host-side batch initiator for the LeNet accelerator: issues one start pulse per image,
// times each run with a watchdog and queues {result, latency, timeout} in a small FWFT FIFO.
module lenet_run_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned CYC_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 3000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_W-1:0]      cmd_count,
  output logic                  acc_start,
  input  logic                  acc_busy,
  input  logic                  acc_done,
  input  logic [DATA_WIDTH-1:0] acc_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [CYC_W-1:0]      res_cycles,
  output logic                  res_timeout,
  output logic [CNT_W-1:0]      img_index,
  output logic                  idle,
  output logic                  err_timeout
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [CYC_W-1:0] TimeoutLat = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0] TimeoutCyc = CYC_W'(TIMEOUT_CYCLES);
  localparam logic [OccW-1:0]  DepthOcc   = OccW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StArm, StPulse, StWait, StPush} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CYC_W-1:0]      cycles;
    logic                  timeout;
  } entry_t;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [CNT_W-1:0]      img_index_q, img_index_d;
  logic [CYC_W-1:0]      lat_q, lat_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic [CYC_W-1:0]      cap_cycles_q, cap_cycles_d;
  logic                  cap_to_q, cap_to_d;
  logic                  err_q, err_d;
  logic                  push, pop;

  entry_t                mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [OccW-1:0]       occ_q;
  entry_t                head;

  // Busy is informational only.
  logic unused_busy;
  assign unused_busy = acc_busy;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    img_index_d  = img_index_q;
    lat_d        = lat_q;
    cap_data_d   = cap_data_q;
    cap_cycles_d = cap_cycles_q;
    cap_to_d     = cap_to_q;
    err_d        = err_q;
    push         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          remaining_d = cmd_count;
          img_index_d = '0;
          if (cmd_count != '0) state_d = StArm;
        end
      end
      // Only start once a FIFO slot is guaranteed for this image's entry.
      StArm: begin
        if (occ_q < DepthOcc) state_d = StPulse;
      end
      StPulse: begin
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (acc_done) begin
          cap_data_d   = acc_result;
          cap_cycles_d = lat_q + 1'b1;
          cap_to_d     = 1'b0;
          state_d      = StPush;
        end else if (lat_q == TimeoutLat) begin
          cap_data_d   = '0;
          cap_cycles_d = TimeoutCyc;
          cap_to_d     = 1'b1;
          err_d        = 1'b1;
          remaining_d  = CNT_W'(1);
          state_d      = StPush;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StPush: begin
        push        = 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == CNT_W'(1)) begin
          state_d = StIdle;
        end else begin
          img_index_d = img_index_q + 1'b1;
          state_d     = StArm;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      img_index_q  <= '0;
      lat_q        <= '0;
      cap_data_q   <= '0;
      cap_cycles_q <= '0;
      cap_to_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      img_index_q  <= img_index_d;
      lat_q        <= lat_d;
      cap_data_q   <= cap_data_d;
      cap_cycles_q <= cap_cycles_d;
      cap_to_q     <= cap_to_d;
      err_q        <= err_d;
    end
  end

  assign pop = res_ready && (occ_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      occ_q <= occ_q + OccW'(push) - OccW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{data: cap_data_q, cycles: cap_cycles_q, timeout: cap_to_q};
  end

  assign head        = mem_q[rptr_q];
  assign res_valid   = (occ_q != '0);
  // Gate the head so the outputs read zero while the FIFO is empty.
  assign res_data    = res_valid ? head.data    : '0;
  assign res_cycles  = res_valid ? head.cycles  : '0;
  assign res_timeout = res_valid ? head.timeout : 1'b0;

  assign cmd_ready   = (state_q == StIdle);
  assign idle        = (state_q == StIdle);
  assign acc_start   = (state_q == StPulse);
  assign img_index   = img_index_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lenet_run_ctrl.sv
// Bench for lenet_run_ctrl: acts as the accelerator and scoreboards the result FIFO.
module tb_lenet_run_ctrl;

  localparam int TIMEOUT = 3000;
  localparam int DEPTH   = 4;
  localparam int NEVER   = 100000;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] c;
    logic        t;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_count;
  logic        acc_start;
  logic        acc_busy;
  logic        acc_done;
  logic        resp_done;
  logic        spur_done;
  logic [7:0]  acc_result;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [15:0] res_cycles;
  logic        res_timeout;
  logic [3:0]  img_index;
  logic        idle;
  logic        err_timeout;

  assign acc_done = resp_done | spur_done;

  lenet_run_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_count   (cmd_count),
    .acc_start   (acc_start),
    .acc_busy    (acc_busy),
    .acc_done    (acc_done),
    .acc_result  (acc_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_cycles  (res_cycles),
    .res_timeout (res_timeout),
    .img_index   (img_index),
    .idle        (idle),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          lat_tab [16];
  logic [7:0]  res_tab [16];
  int          ridx;
  int          cd;
  logic [7:0]  pend_res;
  ent_t        exp_q [$];
  int          exp_left;
  int          batch_img;
  int          batch_pulses;
  logic        err_m;
  int          last_pulse;
  logic        prev_start;
  logic        prev_valid;
  logic        prev_ready;
  logic [7:0]  prev_d;
  logic [15:0] prev_c;
  logic        prev_t;
  logic [7:0]  del_d [$];
  logic [15:0] del_c [$];
  logic        del_t [$];
  int          idx_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accelerator responder plus reference model, evaluated once per cycle at the falling edge.
  task automatic monitor();
    ent_t e;
    cyc++;
    if (!rst_n) begin
      cd         = 0;
      resp_done  = 1'b0;
      acc_busy   = 1'b0;
      exp_q.delete();
      exp_left   = 0;
      err_m      = 1'b0;
      prev_start = 1'b0;
      prev_valid = 1'b0;
      last_pulse = -100;
      return;
    end
    resp_done = 1'b0;
    if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        resp_done  = 1'b1;
        acc_result = pend_res;
      end
    end
    acc_busy = (cd != 0);

    chk("cmd_ready_eq_idle", 32'(cmd_ready), 32'(idle));
    if (cmd_valid && cmd_ready) begin
      exp_left     = int'(cmd_count);
      batch_img    = 0;
      batch_pulses = 0;
      ridx         = 0;
      del_d.delete();
      del_c.delete();
      del_t.delete();
      idx_log.delete();
    end

    if (acc_start) begin
      chk("start_allowed", 32'(exp_left > 0), 1);
      chk("start_width", 32'(prev_start), 0);
      chk("start_gap", 32'((cyc - last_pulse) >= 3), 1);
      chk("fifo_room", 32'(exp_q.size() < DEPTH), 1);
      chk("img_index", 32'(img_index), 32'(batch_img % 16));
      chk("err_sticky", 32'(err_timeout), 32'(err_m));
      idx_log.push_back(int'(img_index));
      if (lat_tab[ridx] > TIMEOUT) begin
        e.d      = 8'd0;
        e.c      = 16'(TIMEOUT);
        e.t      = 1'b1;
        err_m    = 1'b1;
        exp_left = 0;
        cd       = 0;
      end else begin
        e.d      = res_tab[ridx];
        e.c      = 16'(lat_tab[ridx]);
        e.t      = 1'b0;
        cd       = lat_tab[ridx];
        pend_res = res_tab[ridx];
        exp_left--;
      end
      exp_q.push_back(e);
      ridx       = (ridx + 1) % 16;
      batch_img++;
      batch_pulses++;
      last_pulse = cyc;
    end

    if (prev_valid && !prev_ready) begin
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_data", 32'(res_data), 32'(prev_d));
      chk("hold_cycles", 32'(res_cycles), 32'(prev_c));
      chk("hold_timeout", 32'(res_timeout), 32'(prev_t));
    end

    if (res_valid) chk("valid_has_entry", 32'(exp_q.size() > 0), 1);
    if (res_valid && res_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("res_data", 32'(res_data), 32'(e.d));
      chk("res_cycles", 32'(res_cycles), 32'(e.c));
      chk("res_timeout", 32'(res_timeout), 32'(e.t));
      del_d.push_back(res_data);
      del_c.push_back(res_cycles);
      del_t.push_back(res_timeout);
    end

    prev_start = acc_start;
    prev_valid = res_valid;
    prev_ready = res_ready;
    prev_d     = res_data;
    prev_c     = res_cycles;
    prev_t     = res_timeout;
  endtask

  // Sample mid-cycle, then return just after the next rising edge so inputs can be driven.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_img(input int i, input int l, input logic [7:0] r);
    lat_tab[i] = l;
    res_tab[i] = r;
  endtask

  task automatic send_cmd(input int n);
    cmd_valid = 1'b1;
    cmd_count = 4'(n);
    tick();
    cmd_valid = 1'b0;
    cmd_count = 4'd0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !idle; i++) tick();
    chk("reach_idle", 32'(idle), 1);
  endtask

  task automatic wait_pulse(input int budget);
    int i;
    i = 0;
    tick();
    while (!acc_start && i < budget) begin
      tick();
      i++;
    end
    chk("start_seen", 32'(acc_start), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; ridx = 0; cd = 0; pend_res = '0;
    exp_left = 0; batch_img = 0; batch_pulses = 0; err_m = 1'b0; last_pulse = -100;
    prev_start = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    prev_d = '0; prev_c = '0; prev_t = 1'b0;
    for (int i = 0; i < 16; i++) set_img(i, 1, 8'd0);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_count = '0; res_ready = 1'b0;
    spur_done = 1'b0; resp_done = 1'b0; acc_result = '0; acc_busy = 1'b0;

    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_acc_start", 32'(acc_start), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_img_index", 32'(img_index), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_cycles", 32'(res_cycles), 0);
    chk("rst_res_timeout", 32'(res_timeout), 0);
    rst_n = 1'b1;
    tick();

    // Single image, done five cycles after the pulse.
    set_img(0, 5, 8'd7);
    send_cmd(1);
    wait_pulse(20);
    repeat (6) tick();
    chk("t1_idle_in_push", 32'(idle), 0);
    chk("t1_valid_in_push", 32'(res_valid), 0);
    tick();
    chk("t1_idle_after_push", 32'(idle), 1);
    chk("t1_valid", 32'(res_valid), 1);
    chk("t1_data", 32'(res_data), 7);
    chk("t1_cycles", 32'(res_cycles), 5);
    chk("t1_timeout", 32'(res_timeout), 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_drained", 32'(res_valid), 0);
    chk("t1_pulses", 32'(batch_pulses), 1);

    // Three images streamed out with the consumer always ready.
    set_img(0, 2, 8'd3);
    set_img(1, 4, 8'd1);
    set_img(2, 2, 8'd9);
    res_ready = 1'b1;
    send_cmd(3);
    wait_idle(200);
    repeat (3) tick();
    chk("t2_pulses", 32'(batch_pulses), 3);
    chk("t2_count", 32'(del_d.size()), 3);
    chk("t2_d0", 32'(del_d[0]), 3);
    chk("t2_d1", 32'(del_d[1]), 1);
    chk("t2_d2", 32'(del_d[2]), 9);
    chk("t2_c1", 32'(del_c[1]), 4);
    chk("t2_idx0", 32'(idx_log[0]), 0);
    chk("t2_idx1", 32'(idx_log[1]), 1);
    chk("t2_idx2", 32'(idx_log[2]), 2);

    // Six images against a four-deep FIFO with the consumer stalled.
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) set_img(i, 1, 8'(10 + i));
    send_cmd(6);
    repeat (40) tick();
    chk("t3_pulses_stalled", 32'(batch_pulses), 4);
    chk("t3_start_low", 32'(acc_start), 0);
    chk("t3_not_idle", 32'(idle), 0);
    chk("t3_valid", 32'(res_valid), 1);
    chk("t3_head", 32'(res_data), 10);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_pulse(10);
    repeat (10) tick();
    chk("t3_pulses_after_pop", 32'(batch_pulses), 5);
    res_ready = 1'b1;
    wait_idle(100);
    repeat (8) tick();
    chk("t3_count", 32'(del_d.size()), 6);
    for (int i = 0; i < 6; i++) chk("t3_order", 32'(del_d[i]), 32'(10 + i));
    chk("t3_drained", 32'(res_valid), 0);

    // First image never completes: timeout entry, batch aborted.
    set_img(0, NEVER, 8'd0);
    set_img(1, 3, 8'd5);
    send_cmd(2);
    wait_idle(TIMEOUT + 100);
    repeat (3) tick();
    chk("t4_err", 32'(err_timeout), 1);
    chk("t4_pulses", 32'(batch_pulses), 1);
    chk("t4_count", 32'(del_d.size()), 1);
    chk("t4_data", 32'(del_d[0]), 0);
    chk("t4_cycles", 32'(del_c[0]), 3000);
    chk("t4_tflag", 32'(del_t[0]), 1);
    spur_done = 1'b1;
    repeat (2) tick();
    spur_done = 1'b0;
    repeat (5) tick();
    chk("t4_idle_after_late_done", 32'(idle), 1);
    chk("t4_no_entry_late_done", 32'(res_valid), 0);
    chk("t4_no_second_pulse", 32'(batch_pulses), 1);

    // Empty batch.
    send_cmd(0);
    chk("t5_idle", 32'(idle), 1);
    chk("t5_cmd_ready", 32'(cmd_ready), 1);
    repeat (5) tick();
    chk("t5_pulses", 32'(batch_pulses), 0);
    chk("t5_valid", 32'(res_valid), 0);

    // Reset while the second of three images is in flight.
    set_img(0, 3, 8'd1);
    set_img(1, 50, 8'd2);
    set_img(2, 3, 8'd3);
    send_cmd(3);
    wait_pulse(20);
    wait_pulse(20);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_start", 32'(acc_start), 0);
    chk("t6_valid", 32'(res_valid), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_err", 32'(err_timeout), 0);
    chk("t6_cmd_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;
    repeat (6) tick();
    set_img(0, 4, 8'h5A);
    send_cmd(1);
    wait_idle(100);
    repeat (3) tick();
    chk("t6_pulses", 32'(batch_pulses), 1);
    chk("t6_count", 32'(del_d.size()), 1);
    chk("t6_data", 32'(del_d[0]), 32'h5A);
    chk("t6_cycles", 32'(del_c[0]), 4);
    chk("t6_err_clear", 32'(err_timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
